// File: rtl/ftdi_fifo_emulator.sv
// Behavioural stand-in for an FTDI FT245-style FIFO bridge: host-side RX/TX byte
// streams on one side, active-low rxf_n/txe_n/rd_n/wr_n strobes toward the FPGA.
module ftdi_fifo_emulator #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GAP   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               host_data,
  input  logic                     host_valid,
  output logic                     host_ready,
  output logic [7:0]               cap_data,
  output logic                     cap_valid,
  input  logic                     cap_ready,
  output logic                     rxf_n,
  output logic                     txe_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  output logic [7:0]               adbus_out,
  output logic                     adbus_oe,
  input  logic [7:0]               adbus_in,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic                     proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {RD_IDLE, RD_ACTIVE, RD_GAP} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_GAP} wr_state_e;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [7:0]    tx_mem_q [DEPTH];

  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;

  rd_state_e     rd_state_q, rd_state_d;
  wr_state_e     wr_state_q, wr_state_d;
  logic [GW-1:0] rd_gap_q, rd_gap_d, wr_gap_q, wr_gap_d;

  logic          rxf_n_q, rxf_n_d;
  logic          txe_n_q, txe_n_d;
  logic          adbus_oe_q, adbus_oe_d;
  logic [7:0]    adbus_out_q, adbus_out_d;
  logic          proto_err_q, proto_err_d;
  logic          host_ready_q, host_ready_d;
  logic          cap_valid_q, cap_valid_d;

  logic          both_low, rx_push, rx_pop, tx_push, tx_pop, rd_err, wr_err;

  assign both_low = !rd_n && !wr_n;
  assign rx_push  = host_valid && host_ready_q;
  assign tx_pop   = cap_valid_q && cap_ready;

  // Read FSM: a strobe is honoured only when rxf_n was already advertising data
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_gap_d    = rd_gap_q;
    adbus_out_d = adbus_out_q;
    rx_pop      = 1'b0;
    rd_err      = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (!rd_n) begin
          if (both_low || rxf_n_q) begin
            rd_err = 1'b1;
          end else begin
            rd_state_d  = RD_ACTIVE;
            adbus_out_d = rx_mem_q[rx_rptr_q];
          end
        end
      end
      RD_ACTIVE: begin
        if (rd_n) begin
          rx_pop     = 1'b1;
          rd_state_d = RD_GAP;
          rd_gap_d   = GW'(GAP - 1);
        end
      end
      RD_GAP: begin
        if (rd_gap_q == '0) begin
          rd_state_d = RD_IDLE;
        end else begin
          rd_gap_d = rd_gap_q - 1'b1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    adbus_oe_d = (rd_state_d == RD_ACTIVE);
  end

  // Write FSM: the byte is captured on the strobe's leading edge
  always_comb begin
    wr_state_d = wr_state_q;
    wr_gap_d   = wr_gap_q;
    tx_push    = 1'b0;
    wr_err     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (!wr_n) begin
          if (both_low || txe_n_q) begin
            wr_err = 1'b1;
          end else begin
            tx_push    = 1'b1;
            wr_state_d = WR_ACTIVE;
          end
        end
      end
      WR_ACTIVE: begin
        if (wr_n) begin
          wr_state_d = WR_GAP;
          wr_gap_d   = GW'(GAP - 1);
        end
      end
      WR_GAP: begin
        if (wr_gap_q == '0) begin
          wr_state_d = WR_IDLE;
        end else begin
          wr_gap_d = wr_gap_q - 1'b1;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Pointers, occupancy and the flags derived from next-cycle state
  always_comb begin
    rx_wptr_d    = rx_wptr_q + AW'(rx_push);
    rx_rptr_d    = rx_rptr_q + AW'(rx_pop);
    tx_wptr_d    = tx_wptr_q + AW'(tx_push);
    tx_rptr_d    = tx_rptr_q + AW'(tx_pop);
    rx_cnt_d     = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    tx_cnt_d     = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rxf_n_d      = !((rd_state_d == RD_IDLE) && (rx_cnt_d != '0));
    txe_n_d      = !((wr_state_d == WR_IDLE) && (tx_cnt_d < CW'(DEPTH)));
    host_ready_d = (rx_cnt_d < CW'(DEPTH));
    cap_valid_d  = (tx_cnt_d != '0);
    proto_err_d  = proto_err_q || rd_err || wr_err;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
      rx_cnt_q     <= '0;
      tx_cnt_q     <= '0;
      rd_state_q   <= RD_IDLE;
      wr_state_q   <= WR_IDLE;
      rd_gap_q     <= '0;
      wr_gap_q     <= '0;
      rxf_n_q      <= 1'b1;
      txe_n_q      <= 1'b1;
      adbus_oe_q   <= 1'b0;
      adbus_out_q  <= '0;
      proto_err_q  <= 1'b0;
      host_ready_q <= 1'b0;
      cap_valid_q  <= 1'b0;
    end else begin
      rx_wptr_q    <= rx_wptr_d;
      rx_rptr_q    <= rx_rptr_d;
      tx_wptr_q    <= tx_wptr_d;
      tx_rptr_q    <= tx_rptr_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_cnt_q     <= tx_cnt_d;
      rd_state_q   <= rd_state_d;
      wr_state_q   <= wr_state_d;
      rd_gap_q     <= rd_gap_d;
      wr_gap_q     <= wr_gap_d;
      rxf_n_q      <= rxf_n_d;
      txe_n_q      <= txe_n_d;
      adbus_oe_q   <= adbus_oe_d;
      adbus_out_q  <= adbus_out_d;
      proto_err_q  <= proto_err_d;
      host_ready_q <= host_ready_d;
      cap_valid_q  <= cap_valid_d;
    end
  end

  // Storage arrays carry no reset; occupancy alone defines validity
  always_ff @(posedge clock) begin
    if (rx_push) begin
      rx_mem_q[rx_wptr_q] <= host_data;
    end
    if (tx_push) begin
      tx_mem_q[tx_wptr_q] <= adbus_in;
    end
  end

  assign host_ready = host_ready_q;
  assign cap_valid  = cap_valid_q;
  assign cap_data   = tx_mem_q[tx_rptr_q];
  assign rxf_n      = rxf_n_q;
  assign txe_n      = txe_n_q;
  assign adbus_out  = adbus_out_q;
  assign adbus_oe   = adbus_oe_q;
  assign rx_count   = rx_cnt_q;
  assign tx_count   = tx_cnt_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_ftdi_fifo_emulator.sv
// Self-checking bench for ftdi_fifo_emulator: vector table plus scoreboarded
// corner-case sequences (full FIFOs, wrap, protocol errors, mid-transfer reset).
module tb_ftdi_fifo_emulator;

  localparam int DEPTH = 16;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    host_data, cap_data, adbus_out, adbus_in;
  logic          host_valid, host_ready, cap_valid, cap_ready;
  logic          rxf_n, txe_n, rd_n, wr_n, adbus_oe, proto_err;
  logic [CW-1:0] rx_count, tx_count;

  ftdi_fifo_emulator #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clock(clock), .reset(reset),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .cap_data(cap_data), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .rxf_n(rxf_n), .txe_n(txe_n), .rd_n(rd_n), .wr_n(wr_n),
    .adbus_out(adbus_out), .adbus_oe(adbus_oe), .adbus_in(adbus_in),
    .rx_count(rx_count), .tx_count(tx_count), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  typedef enum {OP_PUSH, OP_READ, OP_WRITE, OP_POP} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    int         exp_rx;
    int         exp_tx;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input bit check_en);
    reset = 1'b1; host_valid = 1'b0; cap_ready = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    host_data = '0; adbus_in = '0;
    #2;
    if (check_en) begin
      chk("rst_host_ready", 32'(host_ready), 0);
      chk("rst_cap_valid", 32'(cap_valid), 0);
      chk("rst_rxf_n", 32'(rxf_n), 1);
      chk("rst_txe_n", 32'(txe_n), 1);
      chk("rst_adbus_oe", 32'(adbus_oe), 0);
      chk("rst_adbus_out", 32'(adbus_out), 0);
      chk("rst_proto_err", 32'(proto_err), 0);
      chk("rst_counts", 32'({rx_count, tx_count}), 0);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_host_ready", 32'(host_ready), 1);
    chk("post_rst_txe_n", 32'(txe_n), 0);
    rx_q.delete();
    tx_q.delete();
  endtask

  task automatic wait_rxf();
    int n = 0;
    while (rxf_n !== 1'b0 && n < 100) begin tick(); n++; end
    chk("rxf_n_ready", 32'(rxf_n), 0);
  endtask

  task automatic wait_txe();
    int n = 0;
    while (txe_n !== 1'b0 && n < 100) begin tick(); n++; end
    chk("txe_n_ready", 32'(txe_n), 0);
  endtask

  task automatic host_push(input logic [7:0] b);
    chk("host_ready", 32'(host_ready), 1);
    host_data = b; host_valid = 1'b1;
    rx_q.push_back(b);
    tick();
    host_valid = 1'b0;
  endtask

  // FPGA read pulse of len cycles; optionally a host push lands on the pop cycle
  task automatic fpga_read(input int len, input bit push_en, input logic [7:0] pb);
    wait_rxf();
    chk("adbus_oe_idle", 32'(adbus_oe), 0);
    rd_n = 1'b0;
    for (int i = 0; i < len; i++) begin
      tick();
      chk("adbus_oe_active", 32'(adbus_oe), 1);
      chk("adbus_out", 32'(adbus_out), 32'(rx_q[0]));
      chk("rxf_n_active", 32'(rxf_n), 1);
    end
    rd_n = 1'b1;
    if (push_en) begin
      host_data = pb; host_valid = 1'b1;
      rx_q.push_back(pb);
    end
    tick();
    host_valid = 1'b0;
    void'(rx_q.pop_front());
    chk("adbus_oe_release", 32'(adbus_oe), 0);
    chk("rx_count_read", 32'(rx_count), 32'(rx_q.size()));
    for (int g = 0; g < GAP; g++) begin
      chk("rxf_n_gap", 32'(rxf_n), 1);
      tick();
    end
    chk("rxf_n_after_gap", 32'(rxf_n), 32'(rx_q.size() == 0));
  endtask

  // FPGA write pulse; optionally a cap pop lands on the push cycle
  task automatic fpga_write(input logic [7:0] b, input bit pop_en);
    wait_txe();
    wr_n = 1'b0; adbus_in = b;
    if (pop_en) begin
      chk("cap_valid_wr", 32'(cap_valid), 1);
      chk("cap_data_wr", 32'(cap_data), 32'(tx_q[0]));
      cap_ready = 1'b1;
    end
    tick();
    cap_ready = 1'b0;
    if (pop_en) void'(tx_q.pop_front());
    tx_q.push_back(b);
    chk("txe_n_active", 32'(txe_n), 1);
    chk("tx_count_write", 32'(tx_count), 32'(tx_q.size()));
    wr_n = 1'b1;
    tick();
    for (int g = 0; g < GAP; g++) begin
      chk("txe_n_gap", 32'(txe_n), 1);
      tick();
    end
    chk("txe_n_after_gap", 32'(txe_n), 32'(tx_q.size() == DEPTH));
  endtask

  task automatic cap_pop();
    chk("cap_valid", 32'(cap_valid), 1);
    chk("cap_data", 32'(cap_data), 32'(tx_q[0]));
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    void'(tx_q.pop_front());
    chk("tx_count_pop", 32'(tx_count), 32'(tx_q.size()));
  endtask

  initial begin
    vecs[0]  = '{OP_PUSH,  8'hA5, 1, 0};
    vecs[1]  = '{OP_PUSH,  8'h01, 2, 0};
    vecs[2]  = '{OP_PUSH,  8'h02, 3, 0};
    vecs[3]  = '{OP_READ,  8'h00, 2, 0};
    vecs[4]  = '{OP_READ,  8'h00, 1, 0};
    vecs[5]  = '{OP_READ,  8'h00, 0, 0};
    vecs[6]  = '{OP_WRITE, 8'h77, 0, 1};
    vecs[7]  = '{OP_WRITE, 8'h5A, 0, 2};
    vecs[8]  = '{OP_POP,   8'h00, 0, 1};
    vecs[9]  = '{OP_POP,   8'h00, 0, 0};
    vecs[10] = '{OP_PUSH,  8'h3C, 1, 0};
    vecs[11] = '{OP_WRITE, 8'hC3, 1, 1};
    vecs[12] = '{OP_READ,  8'h00, 0, 1};
    vecs[13] = '{OP_POP,   8'h00, 0, 0};

    do_reset(1'b1);

    for (int i = 0; i < 14; i++) begin
      case (vecs[i].op)
        OP_PUSH:  host_push(vecs[i].data);
        OP_READ:  fpga_read(3, 1'b0, 8'h00);
        OP_WRITE: fpga_write(vecs[i].data, 1'b0);
        default:  cap_pop();
      endcase
      chk($sformatf("vec%0d_rx_count", i), 32'(rx_count), 32'(vecs[i].exp_rx));
      chk($sformatf("vec%0d_tx_count", i), 32'(tx_count), 32'(vecs[i].exp_tx));
    end
    chk("no_proto_err", 32'(proto_err), 0);

    // Simultaneous RX push/pop at occupancy 4, then TX push/pop at occupancy 1
    for (int i = 0; i < 4; i++) host_push(8'(8'h10 + i));
    chk("rx_count_4", 32'(rx_count), 4);
    fpga_read(2, 1'b1, 8'h14);
    chk("rx_count_same_cycle", 32'(rx_count), 4);
    for (int i = 0; i < 4; i++) fpga_read(1, 1'b0, 8'h00);
    fpga_write(8'h40, 1'b0);
    fpga_write(8'h41, 1'b1);
    chk("tx_count_same_cycle", 32'(tx_count), 1);
    cap_pop();

    // Two full fill/drain rounds so both pointers wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) host_push(8'(8'h80 + r * DEPTH + i));
      chk("rx_full_ready", 32'(host_ready), 0);
      host_data = 8'hFF; host_valid = 1'b1;
      tick();
      host_valid = 1'b0;
      chk("rx_full_count", 32'(rx_count), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) fpga_read(1, 1'b0, 8'h00);
      chk("rx_drained", 32'(rx_count), 0);
    end
    chk("no_proto_err_2", 32'(proto_err), 0);

    // TX overflow attempt
    for (int i = 0; i < DEPTH; i++) fpga_write(8'(8'hC0 + i), 1'b0);
    tick();
    chk("tx_full_txe_n", 32'(txe_n), 1);
    chk("tx_full_no_err", 32'(proto_err), 0);
    wr_n = 1'b0;
    tick();
    wr_n = 1'b1;
    tick();
    chk("tx_overflow_err", 32'(proto_err), 1);
    chk("tx_overflow_count", 32'(tx_count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cap_pop();

    // Simultaneous rd_n/wr_n from idle
    do_reset(1'b0);
    host_push(8'h99);
    wait_rxf();
    wait_txe();
    rd_n = 1'b0; wr_n = 1'b0;
    tick();
    chk("both_low_err", 32'(proto_err), 1);
    chk("both_low_oe", 32'(adbus_oe), 0);
    rd_n = 1'b1; wr_n = 1'b1;
    tick();
    chk("both_low_rx", 32'(rx_count), 1);
    chk("both_low_tx", 32'(tx_count), 0);
    chk("both_low_oe2", 32'(adbus_oe), 0);

    // Read strobe with nothing advertised
    do_reset(1'b0);
    chk("empty_rxf_n", 32'(rxf_n), 1);
    rd_n = 1'b0;
    tick();
    chk("bad_read_err", 32'(proto_err), 1);
    chk("bad_read_oe", 32'(adbus_oe), 0);
    rd_n = 1'b1;
    tick();
    chk("bad_read_oe2", 32'(adbus_oe), 0);

    // Reset in the middle of an active read
    do_reset(1'b0);
    host_push(8'h33);
    wait_rxf();
    rd_n = 1'b0;
    tick();
    tick();
    chk("mid_oe", 32'(adbus_oe), 1);
    chk("mid_data", 32'(adbus_out), 32'h33);
    reset = 1'b1;
    #1;
    chk("mid_rst_oe", 32'(adbus_oe), 0);
    rd_n = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_rx_count", 32'(rx_count), 0);
    chk("mid_rst_rxf_n", 32'(rxf_n), 1);
    chk("mid_rst_oe2", 32'(adbus_oe), 0);
    rx_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
